instr_encoder: RTL and testbench

- Program-load engine: the encode side of the CPU instruction decoder.
- Accepts field-level instruction requests over a valid/ready stream, packs each into the 16-bit instruction word the decoder consumes, and writes the words sequentially into program memory.
- Sits between the debug/boot host interface and the instruction ROM/RAM write port.

---
 rtl/instr_encoder_if.sv | 27 ++
 rtl/instr_encoder.sv | 101 ++++++++++
 tb/tb_instr_encoder.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_encoder_if.sv
// Instruction request stream plus program-memory write port of the instruction encoder.
interface instr_encoder_if #(
    parameter int ADDR_W = 15
);
    logic              in_valid;
    logic              in_ready;
    logic              in_kind;
    logic [15:0]       in_imm;
    logic              in_am;
    logic [4:0]        in_alu;
    logic [2:0]        in_dst;
    logic [2:0]        in_jmp;
    logic              in_last;
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [15:0]       prog_data;

    modport master (
        output in_valid, in_kind, in_imm, in_am, in_alu, in_dst, in_jmp, in_last,
        input  in_ready, prog_we, prog_addr, prog_data
    );

    modport slave (
        input  in_valid, in_kind, in_imm, in_am, in_alu, in_dst, in_jmp, in_last,
        output in_ready, prog_we, prog_addr, prog_data
    );
endinterface

// File: rtl/instr_encoder.sv
// Program-load engine: packs field-level instruction requests into 16-bit words
// and writes them to consecutive program-memory addresses.
module instr_encoder #(
    parameter int ADDR_W    = 15,
    parameter int DEPTH     = 32768,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    instr_encoder_if.slave    bus,
    output logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] BASE_C  = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   ONE_C   = (ADDR_W + 1)'(1);

    state_e            state_q;
    logic [ADDR_W:0]   acc_q;
    logic [ADDR_W:0]   count_q;
    logic [1:0]        err_q;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       data_q;

    logic              ready_s;
    logic              accept_s;
    logic              imm_bad_s;
    logic [15:0]       word_d;

    // acc_q counts words already committed to a write slot, so a write still in
    // flight is reserved before count_q catches up one cycle later.
    always_comb begin
        ready_s   = (state_q == S_LOAD) && (acc_q < DEPTH_C) && !start;
        accept_s  = bus.in_valid && ready_s;
        imm_bad_s = !bus.in_kind && bus.in_imm[15];
        if (bus.in_kind) begin
            word_d = {1'b1, 2'b11, bus.in_am, 1'b0, bus.in_alu, bus.in_dst, bus.in_jmp};
        end else begin
            word_d = {1'b0, bus.in_imm[14:0]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            count_q <= '0;
            err_q   <= 2'b00;
            we_q    <= 1'b0;
            addr_q  <= BASE_C;
            data_q  <= 16'h0000;
        end else begin
            we_q <= 1'b0;
            if (start) begin
                state_q <= S_LOAD;
                acc_q   <= '0;
                count_q <= '0;
                err_q   <= 2'b00;
            end else begin
                if (we_q) begin
                    count_q <= count_q + ONE_C;
                    if ((count_q + ONE_C) == DEPTH_C) begin
                        err_q[1] <= 1'b1;
                    end
                end
                if (accept_s) begin
                    if (imm_bad_s) begin
                        err_q[0] <= 1'b1;
                    end else begin
                        we_q   <= 1'b1;
                        addr_q <= BASE_C + acc_q[ADDR_W-1:0];
                        data_q <= word_d;
                        acc_q  <= acc_q + ONE_C;
                    end
                    if (bus.in_last) begin
                        state_q <= S_DONE;
                    end
                end
            end
        end
    end

    assign bus.in_ready  = ready_s;
    assign bus.prog_we   = we_q;
    assign bus.prog_addr = addr_q;
    assign bus.prog_data = data_q;
    assign count         = count_q;
    assign err           = err_q;
    assign busy          = (state_q == S_LOAD);
    assign done          = (state_q == S_DONE);
endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, directed corner cases and
// randomized traffic against a transaction-level reference model.
module tb_instr_encoder;
    localparam int AW    = 15;
    localparam int DEPTH = 8;
    localparam int BASE  = 32'h0100;

    typedef struct {
        logic        kind;
        logic [15:0] imm;
        logic        am;
        logic [4:0]  alu;
        logic [2:0]  dst;
        logic [2:0]  jmp;
        logic        last;
    } beat_t;

    typedef struct {
        beat_t       b;
        logic        exp_we;
        logic [15:0] exp_data;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [1:0]    err;

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.ADDR_W(AW), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bus   (bus),
        .count (count),
        .busy  (busy),
        .done  (done),
        .err   (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model: program state, words accepted/written, sticky errors
    int          m_state;
    int          n_acc;
    int          m_count;
    logic [1:0]  m_err;
    logic        pend;
    logic [14:0] last_addr;
    logic [15:0] last_data;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] encode(input beat_t b);
        if (b.kind)
            return 16'hE000 | (16'(b.am) << 12) | (16'(b.alu) << 6) | (16'(b.dst) << 3) | 16'(b.jmp);
        else
            return b.imm & 16'h7FFF;
    endfunction

    task automatic model_reset();
        m_state   = 0;
        n_acc     = 0;
        m_count   = 0;
        m_err     = 2'b00;
        pend      = 1'b0;
        last_addr = 15'(BASE);
        last_data = 16'h0000;
    endtask

    // one clock: drive at negedge, check ready, then check registered outputs after posedge
    task automatic cycle(input logic st, input logic v, input beat_t b);
        logic exp_rdy;
        logic acc;
        logic nxt_we;
        @(negedge clk);
        start        = st;
        bus.in_valid = v;
        bus.in_kind  = b.kind;
        bus.in_imm   = b.imm;
        bus.in_am    = b.am;
        bus.in_alu   = b.alu;
        bus.in_dst   = b.dst;
        bus.in_jmp   = b.jmp;
        bus.in_last  = b.last;
        #1;
        exp_rdy = (m_state == 1) && (n_acc < DEPTH) && !st;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        acc = v && exp_rdy;
        @(posedge clk);
        #1;
        nxt_we = 1'b0;
        if (st) begin
            m_state = 1;
            n_acc   = 0;
            m_count = 0;
            m_err   = 2'b00;
        end else begin
            if (pend) begin
                m_count++;
                if (m_count == DEPTH) m_err[1] = 1'b1;
            end
            if (acc) begin
                if (!b.kind && b.imm >= 16'h8000) begin
                    m_err[0] = 1'b1;
                end else begin
                    nxt_we    = 1'b1;
                    last_addr = 15'(BASE + n_acc);
                    last_data = encode(b);
                    n_acc++;
                end
                if (b.last) m_state = 2;
            end
        end
        pend = nxt_we;
        chk("prog_we",   32'(bus.prog_we),   32'(nxt_we));
        chk("prog_addr", 32'(bus.prog_addr), 32'(last_addr));
        chk("prog_data", 32'(bus.prog_data), 32'(last_data));
        chk("count",     32'(count),         32'(m_count));
        chk("err",       32'(err),           32'(m_err));
        chk("busy",      32'(busy),          32'(m_state == 1));
        chk("done",      32'(done),          32'(m_state == 2));
    endtask

    function automatic beat_t mk(input logic kind, input logic [15:0] imm, input logic am,
                                 input logic [4:0] alu, input logic [2:0] dst,
                                 input logic [2:0] jmp, input logic last);
        beat_t b;
        b.kind = kind; b.imm = imm; b.am = am; b.alu = alu;
        b.dst = dst; b.jmp = jmp; b.last = last;
        return b;
    endfunction

    function automatic beat_t rnd_beat();
        beat_t b;
        b.kind = 1'($urandom_range(1, 0));
        b.imm  = 16'($urandom_range(16'hFFFF, 0));
        if ($urandom_range(9, 0) != 0) b.imm[15] = 1'b0;
        b.am   = 1'($urandom_range(1, 0));
        b.alu  = 5'($urandom_range(31, 0));
        b.dst  = 3'($urandom_range(7, 0));
        b.jmp  = 3'($urandom_range(7, 0));
        b.last = ($urandom_range(9, 0) == 0);
        return b;
    endfunction

    vec_t  vecs[7];
    beat_t nb;

    initial begin
        nb = mk(1'b0, 16'h0000, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0);
        vecs[0] = '{mk(1'b0, 16'h1234, 1'b0, 5'd0,     3'b000, 3'b000, 1'b1), 1'b1, 16'h1234};
        vecs[1] = '{mk(1'b1, 16'h0000, 1'b1, 5'b00000, 3'b010, 3'b000, 1'b1), 1'b1, 16'hF010};
        vecs[2] = '{mk(1'b1, 16'hFFFF, 1'b0, 5'b00000, 3'b000, 3'b000, 1'b1), 1'b1, 16'hE000};
        vecs[3] = '{mk(1'b0, 16'h7FFF, 1'b1, 5'b11111, 3'b111, 3'b111, 1'b1), 1'b1, 16'h7FFF};
        vecs[4] = '{mk(1'b1, 16'h0000, 1'b0, 5'b11111, 3'b111, 3'b111, 1'b1), 1'b1, 16'hE7FF};
        vecs[5] = '{mk(1'b1, 16'h0000, 1'b1, 5'b10101, 3'b001, 3'b100, 1'b1), 1'b1, 16'hF54C};
        vecs[6] = '{mk(1'b0, 16'h8001, 1'b0, 5'd0,     3'b000, 3'b000, 1'b1), 1'b0, 16'h0000};

        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0; bus.in_kind = 1'b0; bus.in_imm = 16'h0000; bus.in_am = 1'b0;
        bus.in_alu = 5'd0; bus.in_dst = 3'd0; bus.in_jmp = 3'd0; bus.in_last = 1'b0;
        model_reset();
        #12;
        chk("rst_we",    32'(bus.prog_we),   32'd0);
        chk("rst_addr",  32'(bus.prog_addr), 32'(BASE));
        chk("rst_data",  32'(bus.prog_data), 32'd0);
        chk("rst_count", 32'(count),         32'd0);
        chk("rst_err",   32'(err),           32'd0);
        chk("rst_ready", 32'(bus.in_ready),  32'd0);
        chk("rst_busy",  32'(busy),          32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b1, vecs[0].b);

        // vector table: one-instruction programs
        for (int i = 0; i < 7; i++) begin
            cycle(1'b1, 1'b1, vecs[i].b);
            cycle(1'b0, 1'b1, vecs[i].b);
            chk("tbl_we", 32'(bus.prog_we), 32'(vecs[i].exp_we));
            if (vecs[i].exp_we) chk("tbl_data", 32'(bus.prog_data), 32'(vecs[i].exp_data));
            cycle(1'b0, 1'b0, nb);
            chk("tbl_done", 32'(done), 32'd1);
        end

        // four back-to-back beats, last on the fourth
        cycle(1'b1, 1'b0, nb);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, mk(1'b0, 16'(16'h0040 + i), 1'b0, 5'd0, 3'd0, 3'd0, i == 3));
            chk("b2b_addr", 32'(bus.prog_addr), 32'(BASE + i));
        end
        cycle(1'b0, 1'b1, nb);
        chk("b2b_count", 32'(count), 32'd4);
        chk("b2b_done",  32'(done),  32'd1);

        // unencodable immediate between two valid beats
        cycle(1'b1, 1'b0, nb);
        cycle(1'b0, 1'b1, mk(1'b0, 16'h0011, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0));
        cycle(1'b0, 1'b1, mk(1'b0, 16'h8001, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0));
        chk("bad_we", 32'(bus.prog_we), 32'd0);
        cycle(1'b0, 1'b1, mk(1'b1, 16'h0000, 1'b0, 5'd2, 3'd1, 3'd0, 1'b1));
        chk("bad_addr", 32'(bus.prog_addr), 32'(BASE + 1));
        chk("bad_err",  32'(err),           32'd1);

        // overflow: DEPTH+2 beats without last
        cycle(1'b1, 1'b0, nb);
        for (int i = 0; i < DEPTH + 2; i++)
            cycle(1'b0, 1'b1, mk(1'b1, 16'h0000, 1'b0, 5'(i), 3'd2, 3'd0, 1'b0));
        cycle(1'b0, 1'b1, nb);
        chk("ovf_count", 32'(count), 32'(DEPTH));
        chk("ovf_err",   32'(err),   32'd2);
        chk("ovf_busy",  32'(busy),  32'd1);
        cycle(1'b1, 1'b1, nb);
        chk("ovf_clr", 32'(err), 32'd0);
        cycle(1'b0, 1'b1, mk(1'b0, 16'h0077, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0));
        chk("ovf_restart_addr", 32'(bus.prog_addr), 32'(BASE));

        // reset in the middle of a burst
        cycle(1'b0, 1'b1, mk(1'b0, 16'h0078, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0));
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_we",    32'(bus.prog_we), 32'd0);
        chk("mid_rst_count", 32'(count),       32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 1'b1, nb);
        cycle(1'b0, 1'b1, mk(1'b0, 16'h0abc, 1'b0, 5'd0, 3'd0, 3'd0, 1'b0));
        chk("post_rst_addr", 32'(bus.prog_addr), 32'(BASE));
        cycle(1'b0, 1'b0, nb);
        chk("post_rst_count", 32'(count), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(24, 0) == 0, $urandom_range(9, 0) < 7, rnd_beat());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
